clb_lvds_tx_ctrl: RTL and testbench

Camera Link base transmit controller. It accepts a 24-bit pixel stream and generates FVAL/LVAL/DVAL frame timing from a programmable raster. It packs each 28-bit Camera Link word and serializes it 7:1 onto the four LVDS data pairs plus the clock pair of a `clb_lvds_if` instance. It sits between the video pipeline and the LVDS pad ring; `clk` is the serial bit clock, so one pixel slot is 7 `clk` cycles.

---
 rtl/clb_pkg.sv | 38 +++
 rtl/clb_lvds_ser7.sv | 36 +++
 rtl/clb_lvds_tx_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_clb_lvds_tx_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/clb_pkg.sv
// Shared types and constants for the Camera Link base transmit controller.
//   clb_word_t    : one 28-bit Camera Link word (data plus timing flags)
//   clb_state_e   : raster FSM states
//   CLB_CLK_PAT   : serial clock-lane pattern, MSB sent first
//   clb_lane_map  : maps a word onto the four 7-bit data lanes (index 0 = d0)
package clb_pkg;

   localparam int unsigned CLB_DW  = 24;
   localparam int unsigned CLB_SER = 7;

   localparam logic [CLB_SER-1:0] CLB_CLK_PAT = 7'b1100011;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      VBLANK = 2'd1,
      LINE   = 2'd2,
      HBLANK = 2'd3
   } clb_state_e;

   typedef struct packed {
      logic              spare;
      logic              dval;
      logic              fval;
      logic              lval;
      logic [CLB_DW-1:0] data;
   } clb_word_t;

   // Lane bit 6 is transmitted first on each pair.
   function automatic logic [3:0][CLB_SER-1:0] clb_lane_map(input clb_word_t w);
      logic [3:0][CLB_SER-1:0] lanes;
      lanes[0] = w.data[6:0];
      lanes[1] = w.data[13:7];
      lanes[2] = w.data[20:14];
      lanes[3] = {w.spare, w.dval, w.fval, w.lval, w.data[23:21]};
      return lanes;
   endfunction

endpackage

// File: rtl/clb_lvds_ser7.sv
// 7:1 parallel-load serializer for one LVDS pair.
//   clk, rst : bit clock, async active-high reset
//   ld       : load din at this edge (slot boundary); din[6] appears next cycle
//   din      : 7-bit lane word, MSB first
//   p, n     : registered complementary serial outputs
module clb_lvds_ser7
   import clb_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               ld,
   input  logic [CLB_SER-1:0] din,
   output logic               p,
   output logic               n
);

   // Holds the bits still to be sent after the one currently on p.
   logic [CLB_SER-2:0] sr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr <= '0;
         p  <= 1'b0;
         n  <= 1'b1;
      end else if (ld) begin
         sr <= din[CLB_SER-2:0];
         p  <= din[CLB_SER-1];
         n  <= ~din[CLB_SER-1];
      end else begin
         sr <= {sr[CLB_SER-3:0], 1'b0};
         p  <= sr[CLB_SER-2];
         n  <= ~sr[CLB_SER-2];
      end
   end

endmodule

// File: rtl/clb_lvds_tx_ctrl.sv
// Camera Link base transmit controller: raster timing FSM, word packing and
// 7:1 serialization onto one clock pair and four data pairs.
//   clk, rst          : serial bit clock, async active-high reset
//   en                : start/continue frames, sampled at slot boundaries
//   pix_data/valid    : pixel stream input; pix_ready marks the accept cycle
//   busy              : FSM not idle
//   frame_done        : pulse after the last pixel slot of a frame is loaded
//   underrun          : pulse when a line slot is loaded without a pixel
//   clk_p/n, d0..d3_p/n : serial LVDS pairs
module clb_lvds_tx_ctrl
   import clb_pkg::*;
#(
   parameter int unsigned H_ACT   = 640,
   parameter int unsigned V_ACT   = 480,
   parameter int unsigned H_BLANK = 16,
   parameter int unsigned V_BLANK = 64,
   parameter int unsigned CW      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [CLB_DW-1:0] pix_data,
   input  logic              pix_valid,
   output logic              pix_ready,
   output logic              busy,
   output logic              frame_done,
   output logic              underrun,
   output logic              clk_p,
   output logic              clk_n,
   output logic              d0_p,
   output logic              d0_n,
   output logic              d1_p,
   output logic              d1_n,
   output logic              d2_p,
   output logic              d2_n,
   output logic              d3_p,
   output logic              d3_n
);

   localparam int unsigned PW = 3;
   localparam logic [PW-1:0] PH_LAST = PW'(CLB_SER - 1);
   localparam logic [PW-1:0] PH_PRE  = PW'(CLB_SER - 2);

   localparam logic [CW-1:0] H_LAST  = CW'(H_ACT - 1);
   localparam logic [CW-1:0] V_LAST  = CW'(V_ACT - 1);
   localparam logic [CW-1:0] HB_LAST = CW'(H_BLANK - 1);
   localparam logic [CW-1:0] VB_LAST = CW'(V_BLANK - 1);

   logic [PW-1:0] ph;
   logic          slot_end_c;
   logic          accept_c;
   logic          frame_done_c;
   logic          underrun_c;
   clb_state_e    state;
   clb_state_e    state_nxt;
   logic [CW-1:0] blank_cnt;
   logic [CW-1:0] pix_cnt;
   logic [CW-1:0] line_cnt;
   clb_word_t     word_c;
   logic [3:0][CLB_SER-1:0] lanes_c;

   assign slot_end_c = (ph == PH_LAST);
   assign accept_c   = slot_end_c && (state == LINE) && pix_valid;

   // Free-running slot phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ph <= '0;
      else     ph <= slot_end_c ? '0 : ph + PW'(1);
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic; decisions only at slot boundaries.
   always_comb begin
      state_nxt = state;
      if (slot_end_c) begin
         case (state)
            IDLE:    if (en) state_nxt = VBLANK;
            VBLANK:  if (blank_cnt == VB_LAST) state_nxt = LINE;
            LINE: begin
               if (accept_c && (pix_cnt == H_LAST)) begin
                  if (line_cnt == V_LAST) state_nxt = en ? VBLANK : IDLE;
                  else                    state_nxt = HBLANK;
               end
            end
            HBLANK:  if (blank_cnt == HB_LAST) state_nxt = LINE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Word to load and event pulses for the current slot.
   always_comb begin
      word_c       = '0;
      frame_done_c = 1'b0;
      underrun_c   = 1'b0;
      case (state)
         LINE: begin
            word_c.fval = 1'b1;
            word_c.lval = 1'b1;
            if (pix_valid) begin
               word_c.dval = 1'b1;
               word_c.data = pix_data;
            end
            if (slot_end_c) begin
               if (!pix_valid)
                  underrun_c = 1'b1;
               else if ((pix_cnt == H_LAST) && (line_cnt == V_LAST))
                  frame_done_c = 1'b1;
            end
         end
         HBLANK:  word_c.fval = 1'b1;
         default: word_c = '0;
      endcase
   end

   // Raster counters. Leaving VBLANK also clears pix_cnt, which the previous
   // frame's last line left at H_ACT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blank_cnt <= '0;
         pix_cnt   <= '0;
         line_cnt  <= '0;
      end else if (slot_end_c) begin
         case (state)
            IDLE: begin
               blank_cnt <= '0;
               pix_cnt   <= '0;
               line_cnt  <= '0;
            end
            VBLANK: begin
               if (blank_cnt == VB_LAST) begin
                  blank_cnt <= '0;
                  pix_cnt   <= '0;
                  line_cnt  <= '0;
               end else begin
                  blank_cnt <= blank_cnt + CW'(1);
               end
            end
            LINE: begin
               if (accept_c) begin
                  pix_cnt <= pix_cnt + CW'(1);
                  if ((pix_cnt == H_LAST) && (line_cnt != V_LAST))
                     line_cnt <= line_cnt + CW'(1);
               end
            end
            HBLANK: begin
               if (blank_cnt == HB_LAST) begin
                  blank_cnt <= '0;
                  pix_cnt   <= '0;
               end else begin
                  blank_cnt <= blank_cnt + CW'(1);
               end
            end
            default: blank_cnt <= '0;
         endcase
      end
   end

   // Registered status; pix_ready covers exactly the ph==6 cycle of a line slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_ready  <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         pix_ready  <= (ph == PH_PRE) && (state == LINE);
         busy       <= (state_nxt != IDLE);
         frame_done <= frame_done_c;
         underrun   <= underrun_c;
      end
   end

   assign lanes_c = clb_lane_map(word_c);

   clb_lvds_ser7 u_ser_clk (
      .clk (clk), .rst (rst), .ld (slot_end_c), .din (CLB_CLK_PAT),
      .p   (clk_p), .n (clk_n)
   );
   clb_lvds_ser7 u_ser_d0 (
      .clk (clk), .rst (rst), .ld (slot_end_c), .din (lanes_c[0]),
      .p   (d0_p), .n (d0_n)
   );
   clb_lvds_ser7 u_ser_d1 (
      .clk (clk), .rst (rst), .ld (slot_end_c), .din (lanes_c[1]),
      .p   (d1_p), .n (d1_n)
   );
   clb_lvds_ser7 u_ser_d2 (
      .clk (clk), .rst (rst), .ld (slot_end_c), .din (lanes_c[2]),
      .p   (d2_p), .n (d2_n)
   );
   clb_lvds_ser7 u_ser_d3 (
      .clk (clk), .rst (rst), .ld (slot_end_c), .din (lanes_c[3]),
      .p   (d3_p), .n (d3_n)
   );

endmodule

// File: tb/tb_clb_lvds_tx_ctrl.sv
// Testbench for clb_lvds_tx_ctrl with a small raster (4x2, hblank 2, vblank 3).
// Stimulus pushes the expected word of each slot into a queue; a monitor
// deserializes every slot and compares it against the queue head.
module tb_clb_lvds_tx_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en  = 1'b0;
   logic [23:0] pix_data  = '0;
   logic        pix_valid = 1'b0;
   logic        pix_ready, busy, frame_done, underrun;
   logic        clk_p, clk_n, d0_p, d0_n, d1_p, d1_n, d2_p, d2_n, d3_p, d3_n;

   clb_lvds_tx_ctrl #(
      .H_ACT (4), .V_ACT (2), .H_BLANK (2), .V_BLANK (3), .CW (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .pix_data   (pix_data),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .busy       (busy),
      .frame_done (frame_done),
      .underrun   (underrun),
      .clk_p      (clk_p), .clk_n (clk_n),
      .d0_p       (d0_p),  .d0_n  (d0_n),
      .d1_p       (d1_p),  .d1_n  (d1_n),
      .d2_p       (d2_p),  .d2_n  (d2_n),
      .d3_p       (d3_p),  .d3_n  (d3_n)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          slot;
      logic [23:0] d;
      logic        lval, fval, dval, fd, ur, bz;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   logic en_set  = 1'b0;

   // Slot phase and slot index as seen on the serial outputs.
   logic [2:0] b_ph;
   int         bnd_cnt;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         b_ph    <= 3'd0;
         bnd_cnt <= 0;
      end else if (b_ph == 3'd6) begin
         b_ph    <= 3'd0;
         bnd_cnt <= bnd_cnt + 1;
      end else begin
         b_ph <= b_ph + 3'd1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (slot %0d)", name, act, exp, bnd_cnt);
      end
   endtask

   // Monitor: deserialize each slot, check clock lane, pairs, pulses, word.
   logic [6:0]  lc, l0, l1, l2, l3;
   logic [27:0] last_lanes = '0;
   logic        fd0, ur0, bz0, stray, pbad;
   logic        rdy_prev = 1'b0;
   exp_t        e;

   always @(negedge clk) begin
      if (!rst) begin
         if (b_ph == 3'd0) begin
            fd0   = frame_done;
            ur0   = underrun;
            bz0   = busy;
            stray = pix_ready;
            pbad  = 1'b0;
         end else begin
            stray = stray | frame_done | underrun | (pix_ready && (b_ph != 3'd6));
         end
         pbad = pbad | (clk_n !== ~clk_p) | (d0_n !== ~d0_p) | (d1_n !== ~d1_p)
                     | (d2_n !== ~d2_p) | (d3_n !== ~d3_p);
         lc = {lc[5:0], clk_p};
         l0 = {l0[5:0], d0_p};
         l1 = {l1[5:0], d1_p};
         l2 = {l2[5:0], d2_p};
         l3 = {l3[5:0], d3_p};
         if (b_ph == 3'd6) begin
            last_lanes = {l3, l2, l1, l0};
            chk("clk_lane", 32'(lc), (bnd_cnt == 0) ? 32'h00 : 32'h63);
            chk("stray_pulse_or_pair", 32'({stray, pbad}), 32'h0);
            if (q.size() > 0 && q[0].slot < bnd_cnt) begin
               chk("missing_slot", 32'(q[0].slot), 32'(bnd_cnt));
               void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].slot == bnd_cnt) begin
               e = q.pop_front();
               chk("lanes", 32'(last_lanes),
                   32'({1'b0, e.dval, e.fval, e.lval, e.d[23:21],
                        e.d[20:14], e.d[13:7], e.d[6:0]}));
               chk("fd_ur_busy", 32'({fd0, ur0, bz0}), 32'({e.fd, e.ur, e.bz}));
               chk("pix_ready", 32'(rdy_prev), 32'(e.lval));
            end
            rdy_prev = pix_ready;
         end
      end
   end

   // Drive inputs for the next boundary and queue the word it should load.
   task automatic bnd(input logic v, input logic [23:0] pd, input logic [23:0] xd,
                      input logic l, input logic f, input logic dv,
                      input logic fd, input logic ur, input logic bz);
      exp_t x;
      do @(negedge clk); while (b_ph != 3'd3);
      en        = en_set;
      pix_valid = v;
      pix_data  = pd;
      x.slot = bnd_cnt + 1;
      x.d    = xd;
      x.lval = l;
      x.fval = f;
      x.dval = dv;
      x.fd   = fd;
      x.ur   = ur;
      x.bz   = bz;
      q.push_back(x);
   endtask

   // Blank slots keep pix_valid high with junk data that must not be sent.
   task automatic s_idle(input logic bz);
      bnd(1'b1, 24'hBAD001, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, bz);
   endtask
   task automatic s_vb();
      bnd(1'b1, 24'hBAD002, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask
   task automatic s_hb();
      bnd(1'b1, 24'hBAD003, 24'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask
   task automatic s_pix(input logic [23:0] p, input logic fd, input logic bz);
      bnd(1'b1, p, p, 1'b1, 1'b1, 1'b1, fd, 1'b0, bz);
   endtask
   task automatic s_ur();
      bnd(1'b0, 24'hBAD004, 24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Idle with en low: clock lane runs, data lanes quiet, not busy.
      en_set = 1'b0;
      repeat (8) s_idle(1'b0);

      // Frame 1: full raster, pixels 1..8, continues into frame 2.
      en_set = 1'b1;
      s_idle(1'b1);
      repeat (3) s_vb();
      for (int i = 1; i <= 4; i++) s_pix(24'(i), 1'b0, 1'b1);
      repeat (2) s_hb();
      for (int i = 5; i <= 7; i++) s_pix(24'(i), 1'b0, 1'b1);
      s_pix(24'd8, 1'b1, 1'b1);
      repeat (3) s_vb();

      // Frame 2: two underrun slots on line 0, en dropped during line 0.
      s_pix(24'd9, 1'b0, 1'b1);
      s_pix(24'd10, 1'b0, 1'b1);
      s_ur();
      s_ur();
      s_pix(24'd11, 1'b0, 1'b1);
      en_set = 1'b0;
      s_pix(24'd12, 1'b0, 1'b1);
      repeat (2) s_hb();
      for (int i = 13; i <= 15; i++) s_pix(24'(i), 1'b0, 1'b1);
      s_pix(24'd16, 1'b1, 1'b0);
      repeat (2) s_idle(1'b0);

      // Frame 3: known pixel pattern, then reset in the middle of a line.
      en_set = 1'b1;
      s_idle(1'b1);
      repeat (3) s_vb();
      s_pix(24'hA5C3F0, 1'b0, 1'b1);
      s_pix(24'h123456, 1'b0, 1'b1);
      do @(negedge clk); while (b_ph != 3'd3);
      chk("a5c3f0_lanes", 32'(last_lanes),
          32'({7'b0111101, 7'b0010111, 7'b0000111, 7'b1110000}));
      rst = 1'b1;
      q.delete();
      #1;
      chk("reset_outputs",
          32'({clk_p, clk_n, d0_p, d0_n, d1_p, d1_n, d2_p, d2_n, d3_p, d3_n,
               pix_ready, busy, frame_done, underrun}),
          32'({10'b0101010101, 4'b0000}));
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // After release: idle word, full vblank, then line pixels.
      s_idle(1'b1);
      repeat (3) s_vb();
      s_pix(24'h000021, 1'b0, 1'b1);
      s_pix(24'h000022, 1'b0, 1'b1);

      for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
      chk("queue_drained", 32'(q.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      repeat (20000) @(posedge clk);
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
